// File: rtl/custom_ip_reg_if.sv
// APB3 slave for NUM_REGS 32-bit control registers plus a read-only, clear-on-read STATUS word.
// Every access takes exactly one wait state: IDLE -> WAIT -> RESP, committing on the edge that ends RESP.
module custom_ip_reg_if #(
    parameter int NUM_REGS   = 3,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [31:0]             pwdata_i,
    input  logic [3:0]              pstrb_i,
    output logic [31:0]             prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [NUM_REGS*32-1:0]  reg2hw_q_o,
    output logic [NUM_REGS-1:0]     reg2hw_qe_o,
    input  logic [NUM_REGS*32-1:0]  hw2reg_d_i,
    input  logic [NUM_REGS-1:0]     hw2reg_de_i
);
    localparam int IDXW = ADDR_WIDTH - 2;
    localparam logic [IDXW-1:0] STAT_IDX = IDXW'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   write_q;
    logic [31:0]            wdata_q;
    logic [3:0]             strb_q;
    logic                   err_q;
    logic                   abort_q;
    logic                   pready_q;
    logic                   pslverr_q;

    logic [31:0]            regs_q [NUM_REGS];
    logic [31:0]            regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    status_q, status_d;
    logic [NUM_REGS-1:0]    qe_q, qe_d;

    // Setup-phase decode, captured into err_q when the transfer starts
    logic [IDXW-1:0]        setup_idx;
    logic                   setup_err;
    assign setup_idx = paddr_i[ADDR_WIDTH-1:2];
    assign setup_err = (paddr_i[1:0] != 2'b00) || (setup_idx > STAT_IDX)
                     || ((setup_idx == STAT_IDX) && pwrite_i);

    logic [IDXW-1:0]        xfer_idx;
    logic                   commit;
    logic                   stat_clr;
    assign xfer_idx = addr_q[ADDR_WIDTH-1:2];
    assign commit   = (state_q == RESP) && psel_i && !abort_q && !err_q;
    assign stat_clr = commit && !write_q && (xfer_idx == STAT_IDX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        addr_q  <= paddr_i;
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
                        strb_q  <= pstrb_i;
                        err_q   <= setup_err;
                        abort_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A master that lets go of psel here has abandoned the transfer
                    if (!psel_i) begin
                        abort_q <= 1'b1;
                    end
                    pready_q  <= 1'b1;
                    pslverr_q <= err_q;
                    state_q   <= RESP;
                end
                default: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Bus write wins over a same-edge hw update; hw still sets its STATUS bit
    always_comb begin
        status_d = status_q;
        qe_d     = '0;
        if (stat_clr) begin
            status_d = '0;
        end
        for (int n = 0; n < NUM_REGS; n++) begin
            regs_d[n] = regs_q[n];
            if (hw2reg_de_i[n]) begin
                regs_d[n]   = hw2reg_d_i[32*n +: 32];
                status_d[n] = 1'b1;
            end
            if (commit && write_q && (xfer_idx == IDXW'(n))) begin
                qe_d[n] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (strb_q[b]) begin
                        regs_d[n][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= '0;
            end
            status_q <= '0;
            qe_q     <= '0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= regs_d[n];
            end
            status_q <= status_d;
            qe_q     <= qe_d;
        end
    end

    logic [31:0] rdata_mux;
    always_comb begin
        rdata_mux = 32'(status_q);
        for (int n = 0; n < NUM_REGS; n++) begin
            if (xfer_idx == IDXW'(n)) begin
                rdata_mux = regs_q[n];
            end
        end
    end

    assign prdata_o    = ((state_q == RESP) && !write_q && !err_q && !abort_q) ? rdata_mux : 32'h0;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign reg2hw_qe_o = qe_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_q_out
        assign reg2hw_q_o[32*gi +: 32] = regs_q[gi];
    end
endmodule

// File: doc/custom_ip_reg_if.md
CUSTOM_IP_REG_IF -- requirements
Module: custom_ip_reg_if

Interface
REQ-001 SHALL have parameter NUM_REGS, default 3, number of 32-bit control registers (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, APB address width.
REQ-003 SHALL have port clk_i, input, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset: asynchronous assert, active-low.
REQ-005 SHALL have port paddr_i, input, ADDR_WIDTH, APB byte address.
REQ-006 SHALL have ports psel_i, penable_i and pwrite_i, input, 1 each, APB3 select, enable and direction.
REQ-007 SHALL have port pwdata_i, input, 32, write data.
REQ-008 SHALL have port pstrb_i, input, 4, byte write strobes.
REQ-009 SHALL have port prdata_o, output, 32, read data.
REQ-010 SHALL have ports pready_o and pslverr_o, output, 1 each, APB ready and error.
REQ-011 SHALL have port reg2hw_q_o, output, NUM_REGS*32, current register values; register n is bits [32n+31:32n].
REQ-012 SHALL have port reg2hw_qe_o, output, NUM_REGS, one-cycle pulse per register on each bus write.
REQ-013 SHALL have port hw2reg_d_i, input, NUM_REGS*32, hardware update values.
REQ-014 SHALL have port hw2reg_de_i, input, NUM_REGS, hardware update enables.

Function
REQ-015 SHALL map register n at offset 4n and a read-only STATUS register at offset 4*NUM_REGS.
- STATUS bit n is the sticky "hw updated" flag for register n.
- Upper STATUS bits read 0.
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
- IDLE to WAIT: psel_i=1 and penable_i=0. Address, direction, data and strobes are captured.
- WAIT to RESP: unconditional.
- RESP to IDLE: unconditional.
REQ-017 SHALL drive pready_o=1 only in RESP, giving exactly one wait state: pready_o is high on the second access-phase cycle.
REQ-018 SHALL flag an error for any access that is:
- an unmapped offset;
- a misaligned address (paddr_i[1:0]!=0);
- a write to STATUS.

On error, pslverr_o=1 in RESP, prdata_o=0, and no register or flag changes.
REQ-019 SHALL commit a valid write on the clock edge that ends RESP, byte lane b updated only when pstrb_i[b]=1.
REQ-020 SHALL pulse reg2hw_qe_o[n] for exactly one cycle after commit; reg2hw_q_o carries the new value in that same cycle.
- A write with pstrb_i=0 still pulses qe.
REQ-021 SHALL sample prdata_o in RESP from the register value as of that cycle; prdata_o=0 outside RESP.
REQ-022 SHALL load hw2reg_d_i into register n on any cycle with hw2reg_de_i[n]=1, and set STATUS bit n. This does not pulse qe.
REQ-023 SHALL give the bus write priority on the commit edge when it collides with hw2reg_de_i[n] on the same register.
- The hw value is dropped.
- The STATUS bit is still set.
REQ-024 SHALL clear all STATUS bits on the commit edge of a valid STATUS read.
- A hw update in that same cycle leaves its bit set (set wins).
REQ-025 SHALL return IDLE to RESP cleanly if psel_i drops mid-transfer. The transfer is abandoned: no commit, no qe, no STATUS clear.
REQ-026 SHALL ignore back-to-back transfers arriving before RESP completes; a new setup phase is recognised only in IDLE.

Reset
REQ-027 SHALL, while rst_ni=0, force:
- the FSM to IDLE;
- all registers and STATUS bits to 0;
- prdata_o, pready_o, pslverr_o and reg2hw_qe_o to 0.
REQ-028 SHALL abort any in-flight transfer on reset assertion, with no commit; operation resumes on the first rising edge after deassertion.

Verification
REQ-029 SHALL cover a full write: write 0x4 data 0xDEADBEEF strb 0xF -> pready_o high on the 2nd access cycle; next cycle reg2hw_q_o[63:32]=0xDEADBEEF and reg2hw_qe_o=3'b010 for one cycle.
REQ-030 SHALL cover byte strobes: reg0=0x11223344, write 0x0 data 0xAABBCCDD strb 0x5 -> reg0=0x11BB33DD; read 0x0 returns 0x11BB33DD with pslverr_o=0.
REQ-031 SHALL cover errors: write 0x8 with paddr_i[1:0]=2'b10, read 0x20, and write 0xC -> each gives pslverr_o=1 in RESP with prdata_o=0, and no register, qe or STATUS change.
REQ-032 SHALL cover a collision: hw2reg_de_i[2]=1 with d=0x5 on the same edge as a bus write of 0x9 to reg2 -> reg2=0x9, STATUS=3'b100; a following STATUS read returns 0x4, then reads 0x0.
REQ-033 SHALL cover reset mid-transfer: rst_ni low during WAIT of a write to 0x0 -> reg0 stays 0 and no qe pulse; after release a write to 0x0 completes normally.
